row_source_scheduler: RTL
=========================

Name: row_source_scheduler

Overview:
- Configures and sequences which content source feeds each of the four display rows: UART text, binary counter, hex/dec counter, progress bar.
- Sits between the UART receiver and the row-source mux in front of the text engine and screen driver.
- Parses the UART byte stream. Printable bytes go to the text row as column-addressed writes. Escape sequences reprogram the row-to-source map.
- Optionally auto-rotates the map on a fixed tick. Per-row source selection is registered.

Parameters:
- ROTATE_TICKS, 27000000, clk cycles between auto-rotation steps (1 s at 27 MHz); minimum 2.
- COLS, 16, text row width in characters; column index wraps at COLS-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- byte_ready  in  1  single-cycle strobe, byte_data valid
- byte_data  in  8  received UART byte
- row_number  in  2  row currently fetched by the text engine (char address bits 5:4)
- src_sel  out  2  source index for row_number (0 uart, 1 binary, 2 hexdec, 3 progress)
- pixel_mode  out  1  selected source is 3; screen takes pixel data from the progress source
- text_wr_en  out  1  one-cycle write strobe to the text row buffer
- text_wr_col  out  4  write column
- text_wr_data  out  8  write character
- text_clear  out  1  one-cycle clear strobe to the text row buffer
- rotate_en  out  1  auto-rotation active
- cmd_error  out  1  one-cycle pulse on a malformed escape sequence

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n.
- Reset values:
  - map = {row0:0, row1:1, row2:2, row3:3}
  - src_sel=0, pixel_mode=0, text_wr_en=0, text_wr_col=0, text_wr_data=0, text_clear=0, rotate_en=0, cmd_error=0
  - column pointer=0, tick counter=0, FSM=IDLE
- Read path:
  - src_sel <= map[row_number]; pixel_mode <= (map[row_number]==3).
  - Latency is exactly 1 cycle and independent of parser activity.
  - A map update is visible on the cycle after it is written.
- Parser FSM (advances only on byte_ready):
  - IDLE:
    - 0x1B -> ESC.
    - 0x0A or 0x0D: pulse text_clear; column <= 0.
    - 0x20..0x7E: pulse text_wr_en with text_wr_data=byte, text_wr_col=column; then column <= column+1, wrapping COLS-1 -> 0.
    - Any other byte: ignored.
  - ESC:
    - 'M' -> ROW.
    - 'A': toggle rotate_en -> IDLE.
    - 'Z': map <= default, rotate_en <= 0 -> IDLE.
    - Anything else: pulse cmd_error -> IDLE.
  - ROW:
    - '0'..'3': latch target row -> ARG.
    - Else: cmd_error -> IDLE.
  - ARG:
    - '0'..'3': map[target] <= value -> IDLE.
    - Else: cmd_error -> IDLE; map unchanged.
- Strobes (text_wr_en, text_clear, cmd_error) are high for exactly one cycle, one cycle after the byte_ready that caused them.
- Rotation:
  - While rotate_en=1, the tick counter counts 0..ROTATE_TICKS-1.
  - At terminal count: counter <= 0 and map[i] <= map[(i+1) mod 4] for all i, in one cycle.
  - While rotate_en=0, the counter is held at 0. Enabling always starts a full period.
  - Collision: if an ARG map write and a terminal count land in the same cycle, the write is applied, the rotation for that tick is dropped, and the counter restarts at 0.
  - 'Z' in the same cycle as terminal count: 'Z' wins.
- Parse state is not timed out. An incomplete escape waits indefinitely; the next byte_ready resolves it.
- Reset mid-sequence: immediate return to all reset values. No partial map write survives.

Decomposition:
- Shared package (display_pkg):
  - source index constants SRC_UART=0, SRC_BIN=1, SRC_HEXDEC=2, SRC_PROGRESS=3
  - ESC_BYTE=8'h1B
  - command characters 'M', 'A', 'Z'
  - default row map
  - 2-bit source/row typedefs
- One sub-module, rotate_ticker: the enable-gated counter producing a single-cycle terminal pulse with a synchronous restart input.
- The parser FSM and the map registers stay in row_source_scheduler.

Test Plan:
- Reset release, sweep row_number 0..3 -> src_sel 0,1,2,3 one cycle later; pixel_mode=1 only for row 3.
- Bytes "HI", 0x0D, "A" -> writes (col0,'H'), (col1,'I'), then text_clear, then (col0,'A').
- Bytes ESC 'M' '1' '3', then row_number=1 -> src_sel=3 and pixel_mode=1 on the following cycle; rows 0, 2, 3 unchanged.
- Bytes ESC 'M' '5' -> cmd_error pulse, map unchanged. Next byte 'X' is written as text at the current column.
- ROTATE_TICKS=4, ESC 'A' -> rotate_en=1; after 4 cycles map={1,2,3,0}, after 8 cycles map={2,3,0,1}. ESC 'Z' -> default map, rotate_en=0.
- ROTATE_TICKS=4, ARG write timed to coincide with terminal count -> written row holds the new value, other rows unrotated, next rotation 4 cycles later. Assert rst_n low after ESC 'M' -> FSM returns to IDLE and the map stays default.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display row-source path.
package display_pkg;

    typedef logic [1:0] src_t;
    typedef logic [1:0] row_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ESC,
        S_ROW,
        S_ARG
    } parse_state_t;

    localparam src_t SRC_UART     = 2'd0;
    localparam src_t SRC_BIN      = 2'd1;
    localparam src_t SRC_HEXDEC   = 2'd2;
    localparam src_t SRC_PROGRESS = 2'd3;

    localparam src_t [3:0] MAP_DEFAULT =
        {SRC_PROGRESS, SRC_HEXDEC, SRC_BIN, SRC_UART};

    localparam logic [7:0] ESC_BYTE = 8'h1B;
    localparam logic [7:0] CMD_M    = 8'h4D;
    localparam logic [7:0] CMD_A    = 8'h41;
    localparam logic [7:0] CMD_Z    = 8'h5A;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    // ASCII '0'..'3' share the upper six bits 0011_00.
    function automatic logic is_digit03(input logic [7:0] b);
        return b[7:2] == 6'b001100;
    endfunction

endpackage

// File: rtl/row_source_scheduler_rotate_ticker.sv
// Enable-gated period counter with a one-cycle terminal pulse.
module rotate_ticker #(
    parameter int TICKS = 27000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic restart_i,
    output logic tc_o
);

    localparam int W = $clog2(TICKS);
    localparam logic [W-1:0] LAST = W'(TICKS - 1);

    logic [W-1:0] cnt_q;

    assign tc_o = en_i && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i || restart_i || tc_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/row_source_scheduler.sv
// UART command parser and per-row source map with optional auto-rotation.
module row_source_scheduler
    import display_pkg::*;
#(
    parameter int ROTATE_TICKS = 27000000,
    parameter int COLS         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_ready,
    input  logic [7:0] byte_data,
    input  logic [1:0] row_number,
    output logic [1:0] src_sel,
    output logic       pixel_mode,
    output logic       text_wr_en,
    output logic [3:0] text_wr_col,
    output logic [7:0] text_wr_data,
    output logic       text_clear,
    output logic       rotate_en,
    output logic       cmd_error
);

    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    parse_state_t state_q;
    src_t [3:0]   map_q;
    row_t         tgt_q;
    logic [3:0]   col_q;
    logic         tc;
    logic         map_wr;
    logic         cmd_z;
    logic         cmd_a;

    assign map_wr = byte_ready && (state_q == S_ARG)
                    && is_digit03(byte_data);
    assign cmd_z  = byte_ready && (state_q == S_ESC)
                    && (byte_data == CMD_Z);
    assign cmd_a  = byte_ready && (state_q == S_ESC)
                    && (byte_data == CMD_A);

    // A direct write or reset-to-default owns the tick it lands on.
    rotate_ticker #(
        .TICKS(ROTATE_TICKS)
    ) u_ticker (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (rotate_en),
        .restart_i (map_wr | cmd_z | cmd_a),
        .tc_o      (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            map_q        <= MAP_DEFAULT;
            tgt_q        <= '0;
            col_q        <= '0;
            rotate_en    <= 1'b0;
            src_sel      <= '0;
            pixel_mode   <= 1'b0;
            text_wr_en   <= 1'b0;
            text_wr_col  <= '0;
            text_wr_data <= '0;
            text_clear   <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            text_wr_en <= 1'b0;
            text_clear <= 1'b0;
            cmd_error  <= 1'b0;
            src_sel    <= map_q[row_number];
            pixel_mode <= (map_q[row_number] == SRC_PROGRESS);

            if (tc && !map_wr && !cmd_z) begin
                map_q <= {map_q[0], map_q[3:1]};
            end

            if (byte_ready) begin
                unique case (state_q)
                    S_IDLE: begin
                        unique case (1'b1)
                            (byte_data == ESC_BYTE): begin
                                state_q <= S_ESC;
                            end
                            (byte_data == CH_LF),
                            (byte_data == CH_CR): begin
                                text_clear <= 1'b1;
                                col_q      <= '0;
                            end
                            is_printable(byte_data): begin
                                text_wr_en   <= 1'b1;
                                text_wr_col  <= col_q;
                                text_wr_data <= byte_data;
                                col_q <= (col_q == LAST_COL) ?
                                         4'd0 : col_q + 4'd1;
                            end
                            default: ;
                        endcase
                    end
                    S_ESC: begin
                        state_q <= S_IDLE;
                        unique case (byte_data)
                            CMD_M: state_q <= S_ROW;
                            CMD_A: rotate_en <= !rotate_en;
                            CMD_Z: begin
                                map_q     <= MAP_DEFAULT;
                                rotate_en <= 1'b0;
                            end
                            default: cmd_error <= 1'b1;
                        endcase
                    end
                    S_ROW: begin
                        if (is_digit03(byte_data)) begin
                            tgt_q   <= byte_data[1:0];
                            state_q <= S_ARG;
                        end else begin
                            cmd_error <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                    S_ARG: begin
                        state_q <= S_IDLE;
                        if (is_digit03(byte_data)) begin
                            map_q[tgt_q] <= byte_data[1:0];
                        end else begin
                            cmd_error <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule
